// File: rtl/sbox_arbiter_if.sv
// Requester/ROM bundle for sbox_arbiter: two S-box requesters plus the shared ROM port.
// slave = arbiter side, master = requesters and ROM (testbench or surrounding datapath).
interface sbox_arbiter_if;
  logic       req0;
  logic       req1;
  logic [7:0] addr0;
  logic [7:0] addr1;
  logic       en_de0;
  logic       en_de1;
  logic       lock0;
  logic       lock1;
  logic       gnt0;
  logic       gnt1;
  logic       vld0;
  logic       vld1;
  logic [7:0] rsp_data;
  logic [7:0] sbox_in;
  logic       ce;
  logic       re;
  logic       sbox_en_de;
  logic [7:0] sbox_out;

  modport slave (
    input  req0, req1, addr0, addr1, en_de0, en_de1, lock0, lock1, sbox_out,
    output gnt0, gnt1, vld0, vld1, rsp_data, sbox_in, ce, re, sbox_en_de
  );

  modport master (
    output req0, req1, addr0, addr1, en_de0, en_de1, lock0, lock1, sbox_out,
    input  gnt0, gnt1, vld0, vld1, rsp_data, sbox_in, ce, re, sbox_en_de
  );
endinterface

// File: rtl/sbox_arbiter.sv
// Two-requester arbiter in front of a single S-box ROM with optional burst locking.
// SBOX_ARB_RR_EN selects round-robin contention; undefined gives fixed priority to requester 0.
module sbox_arbiter #(
  parameter int unsigned LOCK_MAX = 4
) (
  input logic          clk,
  input logic          rst_n,
  sbox_arbiter_if.slave io_bus
);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  localparam logic [3:0] LockMaxC = 4'(LOCK_MAX);

  state_e     r_state;
  logic [3:0] r_lock_cnt;
  logic       r_last_gnt;
  logic       r_vld0;
  logic       r_vld1;
  logic       r_force_vld;
  logic       r_force_who;

  logic       w_gnt0;
  logic       w_gnt1;
  logic       w_any_gnt;
  logic       w_lock;
  logic       w_same_owner;
  logic [3:0] w_cnt_nxt;

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!rst_n) begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end else if (r_state == StOwn0 && io_bus.req0) begin
      w_gnt0 = 1'b1;
    end else if (r_state == StOwn1 && io_bus.req1) begin
      w_gnt1 = 1'b1;
    end else if (io_bus.req0 && io_bus.req1) begin
      if (r_force_vld) begin
        // Owner just hit LOCK_MAX: the other side gets this cycle.
        w_gnt0 = r_force_who;
        w_gnt1 = ~r_force_who;
      end else begin
`ifdef SBOX_ARB_RR_EN
        w_gnt0 = r_last_gnt;
        w_gnt1 = ~r_last_gnt;
`else
        w_gnt0 = 1'b1;
`endif
      end
    end else begin
      w_gnt0 = io_bus.req0;
      w_gnt1 = io_bus.req1;
    end
  end

  assign w_any_gnt    = w_gnt0 | w_gnt1;
  assign w_lock       = w_gnt0 ? io_bus.lock0 : io_bus.lock1;
  assign w_same_owner = (w_gnt0 && r_state == StOwn0) || (w_gnt1 && r_state == StOwn1);
  assign w_cnt_nxt    = w_same_owner ? (r_lock_cnt + 4'd1) : 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_lock_cnt  <= 4'd0;
      r_last_gnt  <= 1'b1;
      r_vld0      <= 1'b0;
      r_vld1      <= 1'b0;
      r_force_vld <= 1'b0;
      r_force_who <= 1'b0;
    end else begin
      r_vld0      <= w_gnt0;
      r_vld1      <= w_gnt1;
      r_force_vld <= 1'b0;
      if (w_any_gnt) begin
        r_last_gnt <= w_gnt1;
        if (w_lock && (w_cnt_nxt < LockMaxC)) begin
          r_state    <= w_gnt1 ? StOwn1 : StOwn0;
          r_lock_cnt <= w_cnt_nxt;
        end else begin
          r_state    <= StIdle;
          r_lock_cnt <= 4'd0;
          if (w_lock) begin
            r_force_vld <= 1'b1;
            r_force_who <= w_gnt1;
          end
        end
      end else begin
        r_state    <= StIdle;
        r_lock_cnt <= 4'd0;
      end
    end
  end

  assign io_bus.gnt0       = w_gnt0;
  assign io_bus.gnt1       = w_gnt1;
  assign io_bus.ce         = w_any_gnt;
  assign io_bus.re         = w_any_gnt;
  assign io_bus.sbox_in    = w_gnt0 ? io_bus.addr0 : (w_gnt1 ? io_bus.addr1 : 8'h00);
  assign io_bus.sbox_en_de = w_gnt0 ? io_bus.en_de0 : (w_gnt1 ? io_bus.en_de1 : 1'b0);
  assign io_bus.vld0       = r_vld0;
  assign io_bus.vld1       = r_vld1;
  assign io_bus.rsp_data   = (r_vld0 | r_vld1) ? io_bus.sbox_out : 8'h00;

endmodule
